// File: rtl/qea_state_readout.sv
// ---------------------------------------------------------------------------
// qea_state_readout
//
// Readout stage that sits behind QEA once it has finished. A sweep walks the
// QEA state RAM from address 0 up to 2^(N-2)-1 through the i_state_* port.
// Each RAM word carries PE_NUM complex amplitudes. Every amplitude is turned
// into an unsigned fixed-point probability |a|^2 and streamed out on a
// valid/ready port, one amplitude per beat. The running sum of the
// probabilities is kept on o_norm, so the caller can check that the state is
// normalised.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           one-cycle pulse that starts a sweep (ignored while busy)
//   i_qbit_num        qubit count N, sampled on i_start
//   o_state_ena/wea/addra, i_state_dout
//                     read port into the QEA state RAM (wea is always 0)
//   o_prob_valid/i_prob_ready
//                     handshake for the probability stream
//   o_prob_idx        basis index of the beat (addr*PE_NUM + slot)
//   o_prob_data       |a|^2 with NUM_FRAC_BIT fractional bits, saturated
//   o_prob_last       set on the beat with index 2^N-1
//   o_norm            sum of all probabilities transferred in this sweep
//   o_busy            sweep in progress
//   o_done            one-cycle pulse at the end of a sweep or a rejected start
//   o_err             sticky flag: the last start had an illegal qubit count
// ---------------------------------------------------------------------------
module qea_state_readout #(
    parameter int PE_NUM_WIDTH     = 2,
    parameter int PE_NUM           = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT     = 30,
    parameter int RD_LAT           = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]                i_qbit_num,
    output logic                                     o_state_ena,
    output logic                                     o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]              o_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]       i_state_dout,
    output logic                                     o_prob_valid,
    input  logic                                     i_prob_ready,
    output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_prob_idx,
    output logic [DATA_WIDTH-1:0]                    o_prob_data,
    output logic                                     o_prob_last,
    output logic [DATA_WIDTH+STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_norm,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_err
);

    localparam int AW     = STATE_ADDR_WIDTH;
    localparam int DW     = DATA_WIDTH;
    localparam int SDW    = STATE_DATA_WIDTH;
    localparam int NORM_W = DATA_WIDTH + STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    // Smallest legal N addresses a single RAM word; the largest uses every
    // address bit.
    localparam logic [MAX_QBIT_WIDTH-1:0] N_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] N_MAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
    localparam logic [PE_NUM_WIDTH-1:0]   K_LAST = PE_NUM_WIDTH'(PE_NUM - 1);
    localparam logic [LAT_W-1:0]          LAT_LAST = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_SER   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic [AW-1:0]            last_addr_q, last_addr_d;
    logic [PE_NUM_WIDTH-1:0]  k_q, k_d;
    logic [LAT_W-1:0]         lat_cnt_q, lat_cnt_d;
    logic [NORM_W-1:0]        norm_q, norm_d;
    logic                     err_q, err_d;
    logic                     err_done_q, err_done_d;
    logic                     word_load;

    logic [DW-1:0]            prob_calc [PE_NUM];
    logic [DW-1:0]            prob_d    [PE_NUM];
    logic [DW-1:0]            prob_q    [PE_NUM];
    logic [DW-1:0]            prob_cur;

    logic                     qbit_legal;
    logic [MAX_QBIT_WIDTH-1:0] qbit_shift;

    assign qbit_legal = (i_qbit_num >= N_MIN) && (i_qbit_num <= N_MAX);
    assign qbit_shift = i_qbit_num - N_MIN;

    // ------------------------------------------------------------------
    // Probability per slot, computed straight from the RAM output and
    // registered into a word buffer when the read data is valid. Holding
    // finished probabilities (rather than raw amplitudes) keeps the
    // multipliers off the output path and makes the beat contents trivially
    // stable while the consumer stalls.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < PE_NUM; gi++) begin : g_slot
            logic signed [DW-1:0]   re_s;
            logic signed [DW-1:0]   im_s;
            logic signed [2*DW-1:0] re_sq;
            logic signed [2*DW-1:0] im_sq;
            logic [2*DW:0]          mag_sum;
            logic [2*DW:0]          mag_shift;

            assign re_s  = i_state_dout[gi*SDW + DW +: DW];
            assign im_s  = i_state_dout[gi*SDW +: DW];
            assign re_sq = (2*DW)'(re_s) * (2*DW)'(re_s);
            assign im_sq = (2*DW)'(im_s) * (2*DW)'(im_s);
            // Squares are never negative, so the sum is treated as unsigned
            // with one extra bit: (-2.0)^2 + (-2.0)^2 would not fit otherwise.
            assign mag_sum   = {1'b0, re_sq} + {1'b0, im_sq};
            assign mag_shift = mag_sum >> NUM_FRAC_BIT;
            assign prob_calc[gi] = (|mag_shift[2*DW:DW]) ? {DW{1'b1}} : mag_shift[DW-1:0];
            assign prob_d[gi]    = word_load ? prob_calc[gi] : prob_q[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prob_q[gi] <= '0;
                end else begin
                    prob_q[gi] <= prob_d[gi];
                end
            end
        end
    endgenerate

    assign prob_cur = prob_q[k_q];

    // ------------------------------------------------------------------
    // Sweep control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        k_d         = k_q;
        lat_cnt_d   = lat_cnt_q;
        norm_d      = norm_q;
        err_d       = err_q;
        err_done_d  = 1'b0;
        word_load   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    norm_d = '0;
                    err_d  = 1'b0;
                    addr_d = '0;
                    k_d    = '0;
                    if (qbit_legal) begin
                        // 2^(N-2)-1 as a low-order mask; a shift by the full
                        // address width yields all ones, as required for max N.
                        last_addr_d = ~({AW{1'b1}} << qbit_shift);
                        state_d     = S_ISSUE;
                    end else begin
                        err_d      = 1'b1;
                        err_done_d = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                lat_cnt_d = '0;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    word_load = 1'b1;
                    k_d       = '0;
                    state_d   = S_SER;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end

            S_SER: begin
                if (i_prob_ready) begin
                    norm_d = norm_q + NORM_W'(prob_cur);
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        if (addr_q == last_addr_q) begin
                            state_d = S_FIN;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = S_ISSUE;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            k_q         <= '0;
            lat_cnt_q   <= '0;
            norm_q      <= '0;
            err_q       <= 1'b0;
            err_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            k_q         <= k_d;
            lat_cnt_q   <= lat_cnt_d;
            norm_q      <= norm_d;
            err_q       <= err_d;
            err_done_q  <= err_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Beat fields are forced to zero when no beat is offered so the
    // stream looks clean between words and after reset.
    // ------------------------------------------------------------------
    assign o_state_ena   = (state_q == S_ISSUE);
    assign o_state_wea   = 1'b0;
    assign o_state_addra = addr_q;

    assign o_prob_valid  = (state_q == S_SER);
    assign o_prob_idx    = o_prob_valid ? {addr_q, k_q} : '0;
    assign o_prob_data   = o_prob_valid ? prob_cur : '0;
    assign o_prob_last   = o_prob_valid && (k_q == K_LAST) && (addr_q == last_addr_q);

    assign o_norm        = norm_q;
    assign o_busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_SER);
    assign o_done        = (state_q == S_FIN) || err_done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_qea_state_readout.sv
module tb_qea_state_readout;

    localparam int AW   = 16;
    localparam int PW   = 2;
    localparam int NW   = 32 + AW + PW;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_start;
    logic [5:0]           i_qbit_num;
    logic                 o_state_ena;
    logic                 o_state_wea;
    logic [AW-1:0]        o_state_addra;
    logic [255:0]         ram_dout;
    logic                 o_prob_valid;
    logic                 i_prob_ready;
    logic [AW+PW-1:0]     o_prob_idx;
    logic [31:0]          o_prob_data;
    logic                 o_prob_last;
    logic [NW-1:0]        o_norm;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;

    always #5 clk = ~clk;

    qea_state_readout dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_qbit_num    (i_qbit_num),
        .o_state_ena   (o_state_ena),
        .o_state_wea   (o_state_wea),
        .o_state_addra (o_state_addra),
        .i_state_dout  (ram_dout),
        .o_prob_valid  (o_prob_valid),
        .i_prob_ready  (i_prob_ready),
        .o_prob_idx    (o_prob_idx),
        .o_prob_data   (o_prob_data),
        .o_prob_last   (o_prob_last),
        .o_norm        (o_norm),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    // State RAM stand-in: one-cycle registered read.
    logic [255:0] mem [0:15];
    always @(posedge clk) begin
        if (o_state_ena) ram_dout <= mem[o_state_addra[3:0]];
    end

    typedef struct {
        int          idx;
        logic [31:0] data;
        bit          last;
    } beat_t;

    beat_t       exp_q[$];
    logic [NW-1:0] exp_norm;
    int          checks = 0;
    int          errors = 0;
    int          done_count;
    int          rd_count;
    int          beats;
    int          last_seen_idx;
    logic [31:0] got_data [0:31];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // |a|^2 from the amplitude, floor-truncated and saturated to 32 bits.
    function automatic logic [31:0] model_prob(input logic [63:0] amp);
        longint     re, im;
        logic [64:0] s, p;
        re = longint'($signed(amp[63:32]));
        im = longint'($signed(amp[31:0]));
        s  = 65'(re * re) + 65'(im * im);
        p  = s >> 30;
        return (p > 65'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
    endfunction

    task automatic build_expect(input int n);
        logic [255:0] w;
        beat_t b;
        exp_q.delete();
        for (int i = 0; i < (1 << n); i++) begin
            w      = mem[i >> 2];
            b.idx  = i;
            b.data = model_prob(w[(i % 4) * 64 +: 64]);
            b.last = (i == (1 << n) - 1);
            exp_q.push_back(b);
        end
    endtask

    // Compare process: checks every transfer against the model and holds
    // beat contents while the consumer stalls.
    bit          prev_pend;
    logic [AW+PW-1:0] prev_idx;
    logic [31:0] prev_data;
    logic        prev_last;
    beat_t       mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pend = 1'b0;
        end else begin
            if (o_state_ena) rd_count++;
            if (o_state_wea) chk("wea_zero", o_state_wea, 0);
            if (prev_pend) begin
                chk("hold_valid", o_prob_valid, 1);
                chk("hold_idx",   o_prob_idx, prev_idx);
                chk("hold_data",  o_prob_data, prev_data);
                chk("hold_last",  o_prob_last, prev_last);
            end
            if (o_prob_valid) begin
                if (!o_busy) chk("busy_on_valid", o_busy, 1);
                if (i_prob_ready) begin
                    prev_pend = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("beat_idx",  o_prob_idx, mon_e.idx);
                        chk("beat_data", o_prob_data, mon_e.data);
                        chk("beat_last", o_prob_last, mon_e.last);
                        exp_norm = exp_norm + NW'(mon_e.data);
                        beats++;
                        if (o_prob_idx < 32) got_data[o_prob_idx[4:0]] = o_prob_data;
                        if (o_prob_last) last_seen_idx = int'(o_prob_idx);
                    end
                end else begin
                    prev_pend = 1'b1;
                    prev_idx  = o_prob_idx;
                    prev_data = o_prob_data;
                    prev_last = o_prob_last;
                end
            end else begin
                prev_pend = 1'b0;
            end
            if (o_done) begin
                done_count++;
                chk("norm_at_done", o_norm, exp_norm);
            end
        end
    end

    task automatic run_sweep(input int n, input bit bp, input bit mid_start, input bit exp_err);
        bit seen;
        exp_norm      = '0;
        done_count    = 0;
        rd_count      = 0;
        beats         = 0;
        last_seen_idx = -1;
        if (exp_err) exp_q.delete();
        else build_expect(n);
        @(posedge clk); #1;
        i_qbit_num = 6'(n);
        i_start    = 1'b1;
        seen       = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            i_start = mid_start && (c == 12);
            if (mid_start && c == 12) i_qbit_num = 6'd2;
            if (bp) i_prob_ready = (c >= 20 && c < 40) ? 1'b0 : 1'($urandom_range(0, 1));
            else    i_prob_ready = 1'b1;
            if (done_count > 0) begin
                seen = 1'b1;
                break;
            end
        end
        i_start      = 1'b0;
        i_prob_ready = 1'b1;
        chk("done_seen", seen, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", done_count, 1);
        chk("queue_left", exp_q.size(), 0);
        chk("rd_count", rd_count, exp_err ? 0 : (1 << (n - 2)));
        chk("err_flag", o_err, exp_err);
        chk("busy_after", o_busy, 0);
        if (!exp_err) begin
            chk("beat_count", beats, 1 << n);
            chk("last_idx", last_seen_idx, (1 << n) - 1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, o_prob_valid, 0);
        chk({tag, "_idx"},   o_prob_idx, 0);
        chk({tag, "_data"},  o_prob_data, 0);
        chk({tag, "_last"},  o_prob_last, 0);
        chk({tag, "_norm"},  o_norm, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_done"},  o_done, 0);
        chk({tag, "_err"},   o_err, 0);
        chk({tag, "_ena"},   o_state_ena, 0);
        chk({tag, "_addr"},  o_state_addra, 0);
        chk({tag, "_wea"},   o_state_wea, 0);
    endtask

    initial begin
        bit found;
        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_qbit_num   = '0;
        i_prob_ready = 1'b1;
        ram_dout     = '0;
        exp_norm     = '0;
        prev_pend    = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < 32; i++) got_data[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: |0> with N=5
        mem[0] = {192'h0, 64'h40000000_00000000};
        run_sweep(5, 1'b0, 1'b0, 1'b0);
        chk("t1_data0",  got_data[0], 32'h40000000);
        chk("t1_data31", got_data[31], 32'h0);
        chk("t1_norm",   o_norm, 50'h40000000);
        $display("test1 |0> N=5 done, norm=%0h", o_norm);

        // 2: N=2, four slots of 0.5
        mem[0] = {4{64'h20000000_00000000}};
        run_sweep(2, 1'b0, 1'b0, 1'b0);
        chk("t2_data3", got_data[3], 32'h10000000);
        chk("t2_norm",  o_norm, 50'h40000000);
        $display("test2 N=2 uniform done, norm=%0h", o_norm);

        // 3: saturation and exact 2.0
        mem[0] = {64'h0, 64'h0, 64'hC0000000_40000000, 64'h80000000_80000000};
        run_sweep(2, 1'b0, 1'b0, 1'b0);
        chk("t3_sat",   got_data[0], 32'hFFFFFFFF);
        chk("t3_two",   got_data[1], 32'h80000000);
        chk("t3_norm",  o_norm, 50'h17FFFFFFF);
        $display("test3 saturation done, norm=%0h", o_norm);

        // 4: backpressure
        mem[0] = {192'h0, 64'h40000000_00000000};
        run_sweep(5, 1'b1, 1'b0, 1'b0);
        chk("t4_data0", got_data[0], 32'h40000000);
        chk("t4_norm",  o_norm, 50'h40000000);
        $display("test4 backpressure done, beats=%0d", beats);

        // 5: illegal qubit counts
        run_sweep(1, 1'b0, 1'b0, 1'b1);
        chk("t5_norm1", o_norm, 0);
        $display("test5a N=1 rejected, err=%0d", o_err);
        run_sweep(19, 1'b0, 1'b0, 1'b1);
        $display("test5b N=19 rejected, err=%0d", o_err);

        // 6: reset during the beat with idx 9
        build_expect(5);
        exp_norm = '0;
        @(posedge clk); #1;
        i_qbit_num = 6'd5;
        i_start    = 1'b1;
        found      = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            if (o_prob_valid && o_prob_idx == 9) begin
                found = 1'b1;
                break;
            end
        end
        chk("t6_idx9_reached", found, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("test6a reset at idx 9 done");
        run_sweep(5, 1'b0, 1'b0, 1'b0);
        chk("t6_norm", o_norm, 50'h40000000);
        $display("test6b fresh sweep done, beats=%0d", beats);
        run_sweep(5, 1'b0, 1'b1, 1'b0);
        chk("t6_mid_norm", o_norm, 50'h40000000);
        $display("test6c mid-sweep start ignored, beats=%0d", beats);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
